// File: rtl/data_bus_pkg.sv
// Shared definitions for the data_bus slice: IO region decode bit,
// IO word offsets and the UART transmitter state encoding.
package data_bus_pkg;

    // addr[IO_BIT] selects the IO region; clear selects data RAM.
    localparam int unsigned IO_BIT = 22;

    // IO word offsets, decoded from addr[3:2].
    localparam logic [1:0] IO_OFF_LEDS   = 2'd0;
    localparam logic [1:0] IO_OFF_UART   = 2'd1;
    localparam logic [1:0] IO_OFF_CYCLES = 2'd2;
    localparam logic [1:0] IO_OFF_NONE   = 2'd3;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/data_bus_uart_tx.sv
// 8N1 UART transmitter, LSB first, BAUD_DIV clocks per bit.
// Compiled only when DATA_BUS_UART_EN is defined.
`ifdef DATA_BUS_UART_EN
module uart_tx
    import data_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    uart_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_bit_end;

    assign w_bit_end = (r_baud == CW'(BAUD_DIV - 1));

    // State, baud counter, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state and line output; busy covers every non-idle state.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        tx          = 1'b1;
        busy        = (r_state != UART_IDLE);
        case (r_state)
            UART_IDLE: begin
                if (start) begin
                    w_state_nxt = UART_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = data;
                end
            end
            UART_START: begin
                tx = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = UART_DATA;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            UART_DATA: begin
                tx = r_shift[0];
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            UART_STOP: begin
                tx = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = UART_IDLE;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
            end
        endcase
    end

endmodule
`endif

// File: rtl/data_bus.sv
// Data bus for a single-cycle core: zero-latency data RAM plus an IO
// region holding LEDs, a UART transmitter and a free-running cycle counter.
// The UART is present only when DATA_BUS_UART_EN is defined.
module data_bus
    import data_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned BAUD_DIV  = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_leds;
    logic [31:0]   r_cycles;

    logic [AW-1:0] w_idx;
    logic          w_io;
    logic [1:0]    w_off;
    logic          w_uart_busy;
    logic          w_unused;

    // Upper RAM address bits are ignored so RAM aliases across the region.
    assign w_idx    = addr[AW+1:2];
    assign w_io     = addr[IO_BIT];
    assign w_off    = addr[3:2];
    assign leds     = r_leds;
    assign w_unused = ^addr;

    // Byte-lane RAM writes; IO-region writes never reach the array.
    always_ff @(posedge clk) begin
        if (!w_io) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    r_ram[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // LED register and cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds   <= '0;
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_io && (w_off == IO_OFF_LEDS) && wmask[0]) begin
                r_leds <= wdata[7:0];
            end
        end
    end

`ifdef DATA_BUS_UART_EN
    logic w_uart_start;

    assign w_uart_start = w_io && (w_off == IO_OFF_UART) && wmask[0] && !w_uart_busy;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (w_uart_start),
        .data  (wdata[7:0]),
        .tx    (uart_tx),
        .busy  (w_uart_busy)
    );
`else
    localparam int unsigned UNUSED_BAUD_DIV = BAUD_DIV;

    assign uart_tx     = 1'b1;
    assign w_uart_busy = 1'b0;
`endif

    // Combinational read mux; CYCLES returns the pre-increment value.
    always_comb begin
        rdata = '0;
        if (w_io) begin
            case (w_off)
                IO_OFF_LEDS:   rdata = {24'b0, r_leds};
                IO_OFF_UART:   rdata = {31'b0, w_uart_busy};
                IO_OFF_CYCLES: rdata = r_cycles;
                IO_OFF_NONE:   rdata = '0;
                default:       rdata = '0;
            endcase
        end else begin
            rdata = r_ram[w_idx];
        end
    end

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (byte-valid RAM array, LED byte, cycle count, and a
// UART frame described by its start time and payload).
module tb_data_bus;

    localparam int unsigned RW    = 256;
    localparam int unsigned BD    = 4;
    localparam int unsigned FRAME = 10 * BD;
`ifdef DATA_BUS_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int n_cmp = 0;
    int n_err = 0;

    data_bus #(
        .RAM_WORDS (RW),
        .BAUD_DIV  (BD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .wmask   (wmask),
        .rdata   (rdata),
        .leds    (leds),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [RW];
    logic [3:0]  m_val [RW] = '{default: 4'b0000};
    logic [7:0]  m_leds = '0;
    logic [31:0] m_cyc  = '0;
    logic [31:0] m_t0   = '0;
    logic [7:0]  m_byte = '0;
    logic        m_act  = 1'b0;

    function automatic logic m_busy();
        return UART_EN && m_act && ((m_cyc - m_t0) < FRAME);
    endfunction

    function automatic logic m_tx();
        int unsigned b;
        if (!m_busy()) return 1'b1;
        b = (m_cyc - m_t0) / BD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[3'(b - 1)];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, output logic [31:0] mk);
        logic [7:0] idx;
        mk = '1;
        if (a[22]) begin
            case (a[3:2])
                2'd0:    return {24'b0, m_leds};
                2'd1:    return {31'b0, m_busy()};
                2'd2:    return m_cyc;
                default: return 32'b0;
            endcase
        end
        idx = 8'(a >> 2);
        mk  = {{8{m_val[idx][3]}}, {8{m_val[idx][2]}}, {8{m_val[idx][1]}}, {8{m_val[idx][0]}}};
        return m_ram[idx];
    endfunction

    always @(posedge clk) begin
        if (!addr[22]) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    m_ram[8'(addr >> 2)][8*i +: 8] <= wdata[8*i +: 8];
                    m_val[8'(addr >> 2)][i]        <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_leds <= '0;
            m_cyc  <= '0;
            m_act  <= 1'b0;
        end else begin
            if (addr[22] && addr[3:2] == 2'd0 && wmask[0]) m_leds <= wdata[7:0];
            if (UART_EN && addr[22] && addr[3:2] == 2'd1 && wmask[0] && !m_busy()) begin
                m_act  <= 1'b1;
                m_byte <= wdata[7:0];
                m_t0   <= m_cyc + 32'd1;
            end
            m_cyc <= m_cyc + 32'd1;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e, mk;
        e = exp_rd(addr, mk);
        if (mk != 32'b0) check("model_rdata", rdata & mk, e & mk);
        check("model_leds", 32'(leds), 32'(m_leds));
        check("model_tx", 32'(uart_tx), 32'(m_tx()));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        #1;
    endtask

    initial begin
        logic [9:0]  pat;
        logic [31:0] a;
        int unsigned r;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        set(32'h0040_0008, 32'h0, 4'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_tx", 32'(uart_tx), 32'h1);
        check("rst_cycles0", rdata, 32'h0);
        tick();
        check("rst_cycles1", rdata, 32'h1);

        // byte-lane merge
        set(32'h10, 32'hDEAD_BEEF, 4'hF); tick();
        set(32'h10, 32'h00AA_0000, 4'h4); tick();
        set(32'h10, 32'h0, 4'h0);
        check("lane_merge", rdata, 32'hDEAA_BEEF);

        // LED write does not touch RAM word 0
        set(32'h0, 32'h1122_3344, 4'hF); tick();
        set(32'h0040_0000, 32'h0000_00A5, 4'h1); tick();
        set(32'h0040_0000, 32'h0, 4'h0);
        check("leds_port", 32'(leds), 32'hA5);
        check("leds_read", rdata, 32'h0000_00A5);
        set(32'h0, 32'h0, 4'h0);
        check("ram0_kept", rdata, 32'h1122_3344);

        // unmapped IO word and aliasing
        set(32'h0040_000C, 32'h0, 4'h0);
        check("unmapped_rd", rdata, 32'h0);
        set(32'hC, 32'h0BAD_F00D, 4'hF); tick();
        set(32'h0040_000C, 32'hFFFF_FFFF, 4'hF); tick();
        set(32'hC, 32'h0, 4'h0);
        check("io_no_ram", rdata, 32'h0BAD_F00D);
        set(4 * RW, 32'h0, 4'h0);
        check("alias_word0", rdata, 32'h1122_3344);

`ifdef DATA_BUS_UART_EN
        // frame 0x55, dropped write mid-frame and in the busy-clear cycle
        pat = 10'b10_1010_1010;
        set(32'h0040_0004, 32'h55, 4'h1);
        check("uart_idle_busy", rdata, 32'h0);
        tick();
        for (int k = 0; k < int'(FRAME); k++) begin
            if (k == 5)       set(32'h0040_0004, 32'hFF, 4'h1);
            else if (k == 39) set(32'h0040_0004, 32'hA0, 4'h1);
            else              set(32'h0040_0004, 32'h0, 4'h0);
            check("uart_pattern", 32'(uart_tx), 32'(pat[4'(k / int'(BD))]));
            check("uart_busy", rdata, 32'h1);
            tick();
        end
        set(32'h0040_0004, 32'h33, 4'h1);
        check("uart_cleared", rdata, 32'h0);
        check("uart_idle_tx", 32'(uart_tx), 32'h1);
        tick();
        set(32'h0040_0004, 32'h0, 4'h0);
        check("uart_restart_busy", rdata, 32'h1);
        check("uart_restart_start", 32'(uart_tx), 32'h0);
        repeat (4) tick();
        check("uart_new_bit0", 32'(uart_tx), 32'h1);
        repeat (12) tick();
        check("uart_new_bit3", 32'(uart_tx), 32'h0);
        reset = 1'b1;
        #1;
        check("abort_tx", 32'(uart_tx), 32'h1);
        check("abort_busy", rdata, 32'h0);
        check("abort_leds", 32'(leds), 32'h0);
        tick();
        reset = 1'b0;
        set(32'h0040_0008, 32'h0, 4'h0);
        check("abort_cycles0", rdata, 32'h0);
        tick();
        check("abort_cycles1", rdata, 32'h1);
`else
        set(32'h0040_0004, 32'h55, 4'h1); tick();
        set(32'h0040_0004, 32'h0, 4'h0);
        check("nouart_read", rdata, 32'h0);
        check("nouart_tx", 32'(uart_tx), 32'h1);
`endif

        // randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                a = ($urandom & 32'hFFBF_FC00) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
                if (r < 35) set(a, $urandom, 4'($urandom_range(0, 15)));
                else        set(a, $urandom, 4'h0);
            end else if (r < 98) begin
                a = ($urandom & 32'hFFFF_FFF0) | 32'h0040_0000 | (32'($urandom_range(0, 3)) << 2);
                set(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0);
            end else if (r == 98 || i < 100) begin
                set($urandom & 32'hFFBF_FFFF, 32'h0, 4'h0);
            end else begin
                set(addr, 32'h0, 4'h0);
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
